// File: rtl/mm_sequencer.sv
// -----------------------------------------------------------------------------
// mm_sequencer
//
// Control sequencer for a matrix-multiply datapath computing C = A x B for
// square N x N row-major matrices. It walks (i, j, k) with k innermost, issues
// A/B read addresses, drives an external multiply-accumulate unit one cycle
// later, and writes each finished dot product to C two cycles after its last
// read.
//
// Parameters
//   N        matrix dimension (N >= 2)
//   AW       address width, $clog2(N*N) (derived, not overridable)
//
// Ports
//   CLOCK_50 in   sole clock, rising edge
//   KEY0     in   asynchronous active-low reset
//   start    in   begin a multiply (sampled only while idle)
//   abort    in   cancel a run in progress; beats start
//   rd_en    out  A/B read strobe
//   a_addr   out  A address = i*N+k
//   b_addr   out  B address = k*N+j
//   mac_en   out  MAC consumes the product of the current read data
//   mac_clr  out  with mac_en: MAC loads the product instead of adding it
//   c_we     out  write MAC accumulator to C
//   c_addr   out  C address = i*N+j
//   busy     out  run in progress
//   done     out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module mm_sequencer #(
    parameter  int N  = 4,
    localparam int AW = $clog2(N * N)
) (
    input  logic          CLOCK_50,
    input  logic          KEY0,
    input  logic          start,
    input  logic          abort,
    output logic          rd_en,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_reg;

    // Indices of the issue currently presented on a_addr/b_addr.
    logic [CW-1:0]   i_reg;
    logic [CW-1:0]   j_reg;
    logic [CW-1:0]   k_reg;
    logic [CW-1:0]   i_next;
    logic [CW-1:0]   j_next;
    logic [CW-1:0]   k_next;
    logic            last_issue;

    // Second DRAIN cycle marker.
    logic            drain_reg;

    // Stage-1 side information travelling alongside mac_en, needed by stage 2.
    logic            s1_last_reg;
    logic [AW-1:0]   s1_caddr_reg;

    // Row-major linear address of (row, col).
    function automatic logic [AW-1:0] lin_addr(input logic [CW-1:0] row,
                                               input logic [CW-1:0] col);
        return AW'(row) * AW'(N) + AW'(col);
    endfunction

    // Next (i, j, k) in loop order: k innermost, then j, then i.
    always_comb begin
        k_next = k_reg;
        j_next = j_reg;
        i_next = i_reg;
        if (k_reg == CW'(N - 1)) begin
            k_next = '0;
            if (j_reg == CW'(N - 1)) begin
                j_next = '0;
                i_next = (i_reg == CW'(N - 1)) ? '0 : i_reg + 1'b1;
            end else begin
                j_next = j_reg + 1'b1;
            end
        end else begin
            k_next = k_reg + 1'b1;
        end
        last_issue = (i_reg == CW'(N - 1)) && (j_reg == CW'(N - 1)) &&
                     (k_reg == CW'(N - 1));
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_reg    <= IDLE;
            i_reg        <= '0;
            j_reg        <= '0;
            k_reg        <= '0;
            drain_reg    <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_caddr_reg <= '0;
            rd_en        <= 1'b0;
            a_addr       <= '0;
            b_addr       <= '0;
            mac_en       <= 1'b0;
            mac_clr      <= 1'b0;
            c_we         <= 1'b0;
            c_addr       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (abort && (state_reg != IDLE)) begin
            // Cancel: drop every strobe next cycle and empty the pipeline.
            // Addresses keep their last value.
            state_reg   <= IDLE;
            i_reg       <= '0;
            j_reg       <= '0;
            k_reg       <= '0;
            drain_reg   <= 1'b0;
            s1_last_reg <= 1'b0;
            rd_en       <= 1'b0;
            mac_en      <= 1'b0;
            mac_clr     <= 1'b0;
            c_we        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // Stage 1: the read issued last cycle has its data on the bus now.
            mac_en       <= rd_en;
            mac_clr      <= rd_en && (k_reg == '0);
            s1_last_reg  <= rd_en && (k_reg == CW'(N - 1));
            s1_caddr_reg <= lin_addr(i_reg, j_reg);

            // Stage 2: accumulator now holds the finished dot product.
            c_we <= s1_last_reg;
            if (s1_last_reg) begin
                c_addr <= s1_caddr_reg;
            end

            done <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        state_reg <= RUN;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        k_reg     <= '0;
                        a_addr    <= '0;
                        b_addr    <= '0;
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        state_reg <= DRAIN;
                        rd_en     <= 1'b0;
                        drain_reg <= 1'b0;
                    end else begin
                        i_reg  <= i_next;
                        j_reg  <= j_next;
                        k_reg  <= k_next;
                        a_addr <= lin_addr(i_next, k_next);
                        b_addr <= lin_addr(k_next, j_next);
                    end
                end
                DRAIN: begin
                    // Two cycles: lets the last product reach the MAC and
                    // the last C write go out before reporting done.
                    if (drain_reg) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        drain_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mm_sequencer
//
// Two sequencer instances: N=2 for cycle-exact vector tables, abort and
// protocol sequences; N=4 for randomized runs against a cycle-indexed
// reference model and the asynchronous-reset sequence. Each instance has a
// small ROM/MAC/RAM model so the written C contents can be compared with a
// plain matrix product.
// -----------------------------------------------------------------------------
module tb_mm_sequencer;

    localparam int N2 = 2;
    localparam int N4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic key0;
    logic start2, abort2, start4, abort4;
    logic clr2, clr4;

    logic       rd2, me2, mc2, we2, busy2, done2;
    logic [1:0] a2, b2, c2;
    logic       rd4, me4, mc4, we4, busy4, done4;
    logic [3:0] a4, b4, c4;

    mm_sequencer #(.N(N2)) u2 (
        .CLOCK_50(clk), .KEY0(key0), .start(start2), .abort(abort2),
        .rd_en(rd2), .a_addr(a2), .b_addr(b2), .mac_en(me2), .mac_clr(mc2),
        .c_we(we2), .c_addr(c2), .busy(busy2), .done(done2)
    );

    mm_sequencer #(.N(N4)) u4 (
        .CLOCK_50(clk), .KEY0(key0), .start(start4), .abort(abort4),
        .rd_en(rd4), .a_addr(a4), .b_addr(b4), .mac_en(me4), .mac_clr(mc4),
        .c_we(we4), .c_addr(c4), .busy(busy4), .done(done4)
    );

    // ROM (1-cycle latency), MAC and C RAM around each instance.
    int unsigned am2[4], bm2[4], cm2[4];
    int unsigned aq2, bq2, acc2;
    int unsigned am4[16], bm4[16], cm4[16];
    int unsigned aq4, bq4, acc4;

    always @(posedge clk) begin
        if (rd2) begin
            aq2 <= am2[a2];
            bq2 <= bm2[b2];
        end
        if (me2) acc2 <= mc2 ? aq2 * bq2 : acc2 + aq2 * bq2;
        if (clr2) begin
            for (int x = 0; x < 4; x++) cm2[x] <= 32'hDEAD_BEEF;
        end else if (we2) begin
            cm2[c2] <= acc2;
        end
    end

    always @(posedge clk) begin
        if (rd4) begin
            aq4 <= am4[a4];
            bq4 <= bm4[b4];
        end
        if (me4) acc4 <= mc4 ? aq4 * bq4 : acc4 + aq4 * bq4;
        if (clr4) begin
            for (int x = 0; x < 16; x++) cm4[x] <= 32'hDEAD_BEEF;
        end else if (we4) begin
            cm4[c4] <= acc4;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int t, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0d want=%0d", nm, t, act, exp);
        end
    endtask

    // ---------------- N=2 vector table ----------------
    typedef struct {
        logic       rd;
        logic [1:0] a;
        logic [1:0] b;
        logic       me;
        logic       mc;
        logic       we;
        logic [1:0] c;
        logic       busy;
        logic       done;
    } vec2_t;

    vec2_t tbl[1:12];

    function automatic vec2_t v2(input int rd, input int a, input int b,
                                 input int me, input int mc, input int we,
                                 input int c, input int bsy, input int dn);
        vec2_t r;
        r.rd = rd[0]; r.a = 2'(a); r.b = 2'(b);
        r.me = me[0]; r.mc = mc[0]; r.we = we[0]; r.c = 2'(c);
        r.busy = bsy[0]; r.done = dn[0];
        return r;
    endfunction

    // Caller is at the negedge of cycle 1. Rows 1..3 precede the first C
    // write, so c_addr there still holds c_init from the previous run.
    task automatic run2_table(input bit hold_start, input bit chain_next,
                              input logic [1:0] c_init, input int last_row);
        for (int t = 1; t <= last_row; t++) begin
            chk("rd_en",   t, 32'(rd2),   32'(tbl[t].rd));
            chk("a_addr",  t, 32'(a2),    32'(tbl[t].a));
            chk("b_addr",  t, 32'(b2),    32'(tbl[t].b));
            chk("mac_en",  t, 32'(me2),   32'(tbl[t].me));
            chk("mac_clr", t, 32'(mc2),   32'(tbl[t].mc));
            chk("c_we",    t, 32'(we2),   32'(tbl[t].we));
            chk("c_addr",  t, 32'(c2),    (t < 4) ? 32'(c_init) : 32'(tbl[t].c));
            chk("busy",    t, 32'(busy2), 32'(tbl[t].busy));
            chk("done",    t, 32'(done2), 32'(tbl[t].done));
            start2 = (hold_start && t <= 10) || (chain_next && t == 11);
            @(negedge clk);
        end
    endtask

    task automatic chk_c2(input string nm);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                int unsigned s = 0;
                for (int k = 0; k < 2; k++) s += am2[r*2+k] * bm2[k*2+c];
                chk(nm, r*2+c, cm2[r*2+c], s);
            end
    endtask

    task automatic chk_zero2(input string nm, input int t);
        chk({nm, "_rd2"}, t, 32'(rd2), 0);   chk({nm, "_a2"}, t, 32'(a2), 0);
        chk({nm, "_b2"}, t, 32'(b2), 0);     chk({nm, "_me2"}, t, 32'(me2), 0);
        chk({nm, "_mc2"}, t, 32'(mc2), 0);   chk({nm, "_we2"}, t, 32'(we2), 0);
        chk({nm, "_c2"}, t, 32'(c2), 0);     chk({nm, "_busy2"}, t, 32'(busy2), 0);
        chk({nm, "_done2"}, t, 32'(done2), 0);
    endtask

    task automatic chk_zero4(input string nm, input int t);
        chk({nm, "_rd4"}, t, 32'(rd4), 0);   chk({nm, "_a4"}, t, 32'(a4), 0);
        chk({nm, "_b4"}, t, 32'(b4), 0);     chk({nm, "_me4"}, t, 32'(me4), 0);
        chk({nm, "_mc4"}, t, 32'(mc4), 0);   chk({nm, "_we4"}, t, 32'(we4), 0);
        chk({nm, "_c4"}, t, 32'(c4), 0);     chk({nm, "_busy4"}, t, 32'(busy4), 0);
        chk({nm, "_done4"}, t, 32'(done4), 0);
    endtask

    // ---------------- N=4 reference model ----------------
    // Expected addresses hold their last strobed value.
    int ea4 = 0, eb4 = 0, ec4 = 0;

    // ab: cycle in which abort is high (0 = none). rst_at: cycle in which
    // KEY0 is dropped mid-cycle (0 = none).
    task automatic run4(input int ab, input int rst_at);
        int  n, ex_rd, ex_me, ex_mc, ex_we, ex_busy, ex_done;
        bit  alive;
        int  nn, n3;
        nn = N4 * N4;
        n3 = nn * N4;
        for (int x = 0; x < 16; x++) begin
            am4[x] = $urandom_range(0, 255);
            bm4[x] = $urandom_range(0, 255);
        end
        clr4 = 1'b1; @(negedge clk); clr4 = 1'b0;
        start4 = 1'b1; @(negedge clk); start4 = 1'b0;
        for (int t = 1; t <= n3 + 6; t++) begin
            alive = (ab == 0) || (t <= ab);
            n = t - 1;
            ex_rd = (alive && t <= n3) ? 1 : 0;
            if (ex_rd == 1) begin
                ea4 = (n / nn) * N4 + n % N4;
                eb4 = (n % N4) * N4 + (n / N4) % N4;
            end
            ex_me = (alive && t >= 2 && t <= n3 + 1) ? 1 : 0;
            ex_mc = (ex_me == 1 && (t - 2) % N4 == 0) ? 1 : 0;
            ex_we = (alive && t >= N4 + 2 && t <= n3 + 2 && (t - 2) % N4 == 0) ? 1 : 0;
            if (ex_we == 1) ec4 = (t - 2) / N4 - 1;
            ex_busy = (alive && t <= n3 + 2) ? 1 : 0;
            ex_done = (ab == 0 && t == n3 + 3) ? 1 : 0;
            chk("m_rd_en",   t, 32'(rd4),   ex_rd);
            chk("m_a_addr",  t, 32'(a4),    ea4);
            chk("m_b_addr",  t, 32'(b4),    eb4);
            chk("m_mac_en",  t, 32'(me4),   ex_me);
            chk("m_mac_clr", t, 32'(mc4),   ex_mc);
            chk("m_c_we",    t, 32'(we4),   ex_we);
            chk("m_c_addr",  t, 32'(c4),    ec4);
            chk("m_busy",    t, 32'(busy4), ex_busy);
            chk("m_done",    t, 32'(done4), ex_done);
            if (t == rst_at) begin
                #2 key0 = 1'b0;
                #1 chk_zero4("arst_now", t);
                @(negedge clk);
                chk_zero4("arst_hold", t + 1);
                #2 key0 = 1'b1;
                ea4 = 0; eb4 = 0; ec4 = 0;
                @(negedge clk);
                break;
            end
            abort4 = (t == ab);
            @(negedge clk);
        end
        abort4 = 1'b0;
        if (ab == 0 && rst_at == 0) begin
            for (int r = 0; r < N4; r++)
                for (int c = 0; c < N4; c++) begin
                    int unsigned s = 0;
                    for (int k = 0; k < N4; k++) s += am4[r*N4+k] * bm4[k*N4+c];
                    chk("m_cdata", r*N4+c, cm4[r*N4+c], s);
                end
        end
    endtask

    initial begin
        key0 = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; start4 = 1'b0; abort4 = 1'b0;
        clr2 = 1'b0; clr4 = 1'b0;
        //          rd a  b  me mc we c  bsy dn
        tbl[1]  = v2(1, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[2]  = v2(1, 1, 2, 1, 1, 0, 0, 1, 0);
        tbl[3]  = v2(1, 0, 1, 1, 0, 0, 0, 1, 0);
        tbl[4]  = v2(1, 1, 3, 1, 1, 1, 0, 1, 0);
        tbl[5]  = v2(1, 2, 0, 1, 0, 0, 0, 1, 0);
        tbl[6]  = v2(1, 3, 2, 1, 1, 1, 1, 1, 0);
        tbl[7]  = v2(1, 2, 1, 1, 0, 0, 1, 1, 0);
        tbl[8]  = v2(1, 3, 3, 1, 1, 1, 2, 1, 0);
        tbl[9]  = v2(0, 3, 3, 1, 0, 0, 2, 1, 0);
        tbl[10] = v2(0, 3, 3, 0, 0, 1, 3, 1, 0);
        tbl[11] = v2(0, 3, 3, 0, 0, 0, 3, 0, 1);
        tbl[12] = v2(0, 3, 3, 0, 0, 0, 3, 0, 0);

        // Reset held: outputs zero before any clock edge and while start toggles.
        #3;
        chk_zero2("rst", 0);
        chk_zero4("rst", 0);
        for (int c = 1; c <= 3; c++) begin
            start2 = ~start2; start4 = ~start4;
            @(negedge clk);
            chk_zero2("rst", c);
            chk_zero4("rst", c);
        end
        start2 = 1'b0; start4 = 1'b0;
        key0 = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("idle_busy2", c, 32'(busy2), 0);
            chk("idle_rd2",   c, 32'(rd2),   0);
            chk("idle_busy4", c, 32'(busy4), 0);
        end

        // N=2 run with A=[[1,2],[3,4]], B=[[5,6],[7,8]].
        am2 = '{1, 2, 3, 4};
        bm2 = '{5, 6, 7, 8};
        clr2 = 1'b1; @(negedge clk); clr2 = 1'b0;
        start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        run2_table(1'b0, 1'b0, 2'd0, 12);
        chk("c00", 0, cm2[0], 19);
        chk("c01", 1, cm2[1], 22);
        chk("c10", 2, cm2[2], 43);
        chk("c11", 3, cm2[3], 50);

        // A = identity, start held through the run and raised again in the
        // done cycle: exactly one run, then a chained second run.
        am2 = '{1, 0, 0, 1};
        clr2 = 1'b1; @(negedge clk); clr2 = 1'b0;
        start2 = 1'b1; @(negedge clk);
        run2_table(1'b1, 1'b1, 2'd3, 11);
        chk_c2("ident_c");
        clr2 = 1'b1;
        run2_table(1'b0, 1'b0, 2'd3, 1);
        clr2 = 1'b0;
        // Cycle 2 onward of the chained run (rows 2..12 of the same table).
        for (int t = 2; t <= 12; t++) begin
            chk("ch_rd_en", t, 32'(rd2),   32'(tbl[t].rd));
            chk("ch_a",     t, 32'(a2),    32'(tbl[t].a));
            chk("ch_b",     t, 32'(b2),    32'(tbl[t].b));
            chk("ch_we",    t, 32'(we2),   32'(tbl[t].we));
            chk("ch_busy",  t, 32'(busy2), 32'(tbl[t].busy));
            chk("ch_done",  t, 32'(done2), 32'(tbl[t].done));
            @(negedge clk);
        end
        // C was cleared during cycle 1; writes occur later, so it is rebuilt.
        chk_c2("chain_c");

        // Abort in cycle 5: everything low from cycle 6, no done.
        am2 = '{1, 2, 3, 4};
        start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            if (t < 6) begin
                chk("ab_rd_pre",   t, 32'(rd2),   1);
                chk("ab_busy_pre", t, 32'(busy2), 1);
            end else begin
                chk("ab_rd",   t, 32'(rd2),   0);
                chk("ab_me",   t, 32'(me2),   0);
                chk("ab_mc",   t, 32'(mc2),   0);
                chk("ab_we",   t, 32'(we2),   0);
                chk("ab_busy", t, 32'(busy2), 0);
                chk("ab_done", t, 32'(done2), 0);
            end
            abort2 = (t == 5);
            @(negedge clk);
        end
        abort2 = 1'b0;
        // Full run after the abort.
        clr2 = 1'b1; @(negedge clk); clr2 = 1'b0;
        start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        run2_table(1'b0, 1'b0, 2'd0, 12);
        chk("pa_c00", 0, cm2[0], 19);
        chk("pa_c11", 3, cm2[3], 50);

        // Abort while idle suppresses start.
        abort2 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0; start2 = 1'b0;
        chk("idle_abort_busy", 1, 32'(busy2), 0);
        chk("idle_abort_rd",   1, 32'(rd2),   0);
        @(negedge clk);
        chk("idle_abort_busy", 2, 32'(busy2), 0);

        // N=4 randomized runs, some with an abort at a random cycle.
        for (int r = 0; r < 6; r++) begin
            int gap;
            int ab;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) @(negedge clk);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 66) : 0;
            run4(ab, 0);
        end

        // Asynchronous reset mid-cycle 7, then a complete run.
        run4(0, 7);
        chk("post_arst_busy", 0, 32'(busy4), 0);
        run4(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mm_sequencer.md
# mm_sequencer

Control sequencer for the matrix-multiply datapath: computes C = A×B for square N×N matrices held row-major in single-port, 1-cycle-latency read memories. Issues A/B read addresses, drives the external multiply-accumulate unit (mac_en/mac_clr), and issues C write strobes. Sits between the top-level start/reset logic (CLOCK_50/KEY0 domain) and the A/B ROMs, MAC and C RAM; its done pulse is what the top level exports as `done`.

## Interface
- N, default 4: matrix dimension, N ≥ 2.
- AW, derived localparam = $clog2(N*N): address width, not overridable.

- CLOCK_50  in  1  sole clock, rising-edge.
- KEY0  in  1  asynchronous active-low reset.
- start  in  1  begin a multiply; sampled in IDLE only.
- abort  in  1  cancel a run in progress; priority over start.
- rd_en  out  1  A/B read strobe.
- a_addr  out  AW  A address = i*N+k.
- b_addr  out  AW  B address = k*N+j.
- mac_en  out  1  MAC accumulates product of current read data.
- mac_clr  out  1  with mac_en: MAC loads product instead of adding.
- c_we  out  1  write MAC accumulator to C.
- c_addr  out  AW  C address = i*N+j.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: rd_en, mac_en, c_we, busy low. start=1 and abort=0 at an edge → RUN with i=j=k=0.
- RUN: every cycle rd_en=1 with addresses for current (i,j,k). Loop order: k innermost, then j, then i; no bubbles across (i,j) boundaries. After issuing (N-1,N-1,N-1) → DRAIN.
- Pipeline stage 1 (1 cycle after issue): mac_en=1; mac_clr=1 iff that issue had k=0.
- Pipeline stage 2 (2 cycles after issue): if that issue had k=N-1, c_we=1 with c_addr=i*N+j of that issue.
- DRAIN: lasts 2 cycles, rd_en=0, flushes pipeline; then → IDLE and done=1 in the first IDLE cycle.
- start during RUN/DRAIN ignored. start in the done cycle is accepted (state is IDLE).
- abort=1 in RUN/DRAIN: next edge → IDLE; rd_en, mac_en, mac_clr, c_we forced low from next cycle and pipeline flags cleared; no done pulse. abort in IDLE: no effect, start suppressed.
- Counters i, j, k wrap from N-1 to 0; AW-bit address arithmetic, no overflow since max address N*N-1.
- a_addr/b_addr/c_addr hold last value when their strobe is low.

## Timing
- Reset (KEY0=0, asynchronous, any state): state IDLE, i=j=k=0, all outputs 0 (addresses 0, strobes 0, busy 0, done 0) immediately, no clock needed. Mid-run reset discards the run, no done.
- Start accepted at edge E0; cycle t = t-th cycle after E0.
- Issue cycles 1..N³; busy=1 cycles 1..N³+2.
- c_we for element (i,j) in cycle (i*N+j+1)*N+2.
- done=1 in cycle N³+3 only; busy=0 in that cycle. Start-to-done latency N³+3 cycles.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- Reset: hold KEY0=0, toggle start → all outputs 0; release → remains IDLE until start.
- N=2 sequence: start pulse → cycles 1..8 a_addr 0,1,0,1,2,3,2,3 and b_addr 0,2,1,3,0,2,1,3; mac_clr in cycles 2,4,6,8; c_we in cycles 4,6,8,10 with c_addr 0,1,2,3; done only in cycle 11.
- N=2 data with bench memory/MAC model: A=[[1,2],[3,4]], B=[[5,6],[7,8]] → C written 19,22,43,50; repeat with A=identity → C=B.
- Protocol: start held high through whole run → single run, no restart until IDLE; start high in the done cycle → second run, issue begins next cycle, second done at +11 cycles.
- Abort in cycle 5 (N=2) → from cycle 6 rd_en/mac_en/c_we low, busy low, no done; subsequent start produces full correct run.
- Async reset: drop KEY0 mid-cycle in cycle 7 of N=4 run → outputs clear without clock edge; after release, start → done at cycle 67.
